sobel_edge_streamer: RTL
========================

# sobel_edge_streamer

Output stage directly downstream of `sobel_top`. It consumes the unthrottled `edge_out`/`edge_valid` pixel stream, tags each pixel with frame geometry (start-of-frame, end-of-line, end-of-frame), and buffers the tagged pixels in a small FIFO. Pixels leave on a valid/ready stream so a display or DMA sink can apply backpressure. Overflow is detected and reported without losing frame alignment.

## Interface
Parameters:
- `IMG_WIDTH`, 256: pixels per line of the incoming edge stream.
- `IMG_HEIGHT`, 256: lines per frame.
- `FIFO_DEPTH`, 16: buffer entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock for the block.
- `rst` in 1: asynchronous, active-high reset.
- `edge_in` in 8: edge magnitude from `sobel_top.edge_out`.
- `edge_in_valid` in 1: from `sobel_top.edge_valid`. Has no backpressure.
- `threshold` in 8: binarisation threshold. Used only with `SOBEL_BINARIZE_EN`.
- `overflow_clr` in 1: synchronous clear of `overflow`.
- `m_data` out 8: output pixel.
- `m_valid` out 1: output pixel available.
- `m_ready` in 1: sink accepts pixel.
- `m_sof` out 1: `m_data` is pixel (0,0) of a frame.
- `m_eol` out 1: `m_data` is the last pixel of a line.
- `m_eof` out 1: `m_data` is the last pixel of a frame.
- `overflow` out 1: sticky; set when an input pixel was dropped.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current number of entries.
- `frame_count` out 16: frames fully delivered. Wraps 0xFFFF→0.

## Operation
**Geometry counters**
- `col` counts 0..IMG_WIDTH-1 and `row` counts 0..IMG_HEIGHT-1.
- Both advance on every `edge_in_valid` cycle, including dropped pixels, so tags stay aligned after an overflow.
- `col` wraps to 0 after IMG_WIDTH-1 and increments `row`.
- `row` wraps to 0 after IMG_HEIGHT-1.

**Tags** (computed from the pre-increment counter values)
- sof = (col==0 && row==0).
- eol = (col==IMG_WIDTH-1).
- eof = eol && (row==IMG_HEIGHT-1).

**FIFO**
- Entries are 11 bits: {sof, eol, eof, pixel}. Storage is a circular buffer with wrapping read/write pointers.
- A write occurs when `edge_in_valid` && (level<FIFO_DEPTH || pop this cycle). Full with a simultaneous pop is a legal write.
- A pop occurs when `m_valid && m_ready`.
- If `edge_in_valid` arrives while full and there is no pop:
  - the pixel is discarded;
  - `overflow` is set the next cycle;
  - the counters still advance.
- `overflow` stays set until `overflow_clr` or `rst`. If set and clear coincide, set wins.

**Output**
- `m_valid` = (level != 0).
- `m_data` and the tags present the head entry (show-ahead).
- While `m_valid && !m_ready`, `m_data`, `m_sof`, `m_eol` and `m_eof` hold stable.
- `frame_count` increments on the cycle after an accepted pop whose eof tag is 1.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_sof`/`m_eol`/`m_eof`=0, `overflow`=0, `fifo_level`=0, `frame_count`=0. Counters, pointers and FIFO level are also cleared.
- Reset mid-frame discards all buffered pixels. The next valid input is treated as pixel (0,0).
- Latency: a pixel written into an empty FIFO at edge N makes `m_valid`=1 with that pixel after edge N; it is poppable at edge N+1.
- Throughput: one pixel per cycle in and out.
- With simultaneous push and pop, `fifo_level` is unchanged. This also holds when full.
- `fifo_level` is registered and reflects completed pushes and pops.

## Configuration
- `SOBEL_BINARIZE_EN` defined:
  - the stored pixel is 8'hFF if `edge_in` ≥ `threshold`, else 8'h00;
  - `threshold` is sampled on the same edge as the pixel.
- `SOBEL_BINARIZE_EN` undefined:
  - `edge_in` is stored unmodified;
  - `threshold` is ignored.
- Timing and tags are identical in both builds.

## Test plan
Benches use IMG_WIDTH=4, IMG_HEIGHT=2, FIFO_DEPTH=4 unless stated.
- **Full frame, no backpressure.** Drive 8 valid pixels 0x10..0x17 with `m_ready`=1 → outputs 0x10..0x17 in order. Each pixel appears 1 cycle after input. `m_sof` is on 0x10, `m_eol` on 0x13 and 0x17, `m_eof` on 0x17. `frame_count`=1 after the last pop.
- **Backpressure hold.** Hold `m_ready`=0 and push 3 pixels → `fifo_level`=3 and `m_data` holds the first pixel stable. Release `m_ready` → 3 pops in order, then `m_valid`=0.
- **Overflow.** Hold `m_ready`=0 and push 6 pixels → `fifo_level`=4 and `overflow`=1 after the 5th push. Drain → first 4 pixels come out. Push the next frame → `m_sof` is on its first pixel (alignment preserved). `overflow_clr` → `overflow`=0.
- **Full with simultaneous push and pop.** With level 4, `m_ready`=1 and `edge_in_valid`=1 → no drop, level stays 4, `overflow` stays 0.
- **Reset mid-frame.** Push 5 pixels, assert `rst` asynchronously → all outputs return to their reset values immediately. The next input carries `m_sof`=1.
- **Binarisation.** With `SOBEL_BINARIZE_EN` and `threshold`=0x80, inputs 0x7F, 0x80, 0xFF → outputs 0x00, 0xFF, 0xFF. Without the macro → outputs 0x7F, 0x80, 0xFF.

Source files
------------

// File: rtl/sobel_edge_streamer.sv
// Tags the Sobel edge pixel stream with frame geometry and buffers it behind a valid/ready output.
// Optional build macro SOBEL_BINARIZE_EN stores thresholded pixels (8'hFF / 8'h00) instead of raw magnitudes.
module sobel_edge_streamer #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      edge_in,
  input  logic                            edge_in_valid,
  input  logic [7:0]                      threshold,
  input  logic                            overflow_clr,
  output logic [7:0]                      m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            m_sof,
  output logic                            m_eol,
  output logic                            m_eof,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     frame_count
);

  localparam int DATA_W  = 8;
  localparam int ENTRY_W = DATA_W + 3;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int COL_W   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        frame_count_q, frame_count_d;

  logic               full, push, pop, drop;
  logic               tag_sof, tag_eol, tag_eof;
  logic [DATA_W-1:0]  wr_pix;
  logic [ENTRY_W-1:0] wr_entry, head;

`ifdef SOBEL_BINARIZE_EN
  always_comb wr_pix = (edge_in >= threshold) ? 8'hFF : 8'h00;
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  always_comb wr_pix = edge_in;
`endif

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    full     = (level_q == LVL_FULL);
    pop      = (level_q != '0) && m_ready;
    // A full buffer still accepts a write when the head leaves on the same edge.
    push     = edge_in_valid && (!full || pop);
    drop     = edge_in_valid && full && !pop;
    tag_sof  = (col_q == '0) && (row_q == '0);
    tag_eol  = (col_q == COL_LAST);
    tag_eof  = tag_eol && (row_q == ROW_LAST);
    wr_entry = {tag_sof, tag_eol, tag_eof, wr_pix};

    col_d         = col_q;
    row_d         = row_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    frame_count_d = frame_count_q;

    // Geometry follows every input pixel, dropped or not, so tags stay frame-aligned.
    if (edge_in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    overflow_d = drop || (overflow_q && !overflow_clr);
    if (pop && head[DATA_W]) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Storage is never cleared, so outputs are masked while the buffer is empty.
  always_comb begin
    m_valid     = (level_q != '0);
    m_data      = m_valid ? head[DATA_W-1:0] : '0;
    m_sof       = m_valid && head[DATA_W+2];
    m_eol       = m_valid && head[DATA_W+1];
    m_eof       = m_valid && head[DATA_W];
    overflow    = overflow_q;
    fifo_level  = level_q;
    frame_count = frame_count_q;
  end

endmodule
